dadda_mac_accum: RTL and testbench

Streaming accumulator placed directly downstream of the 8x8 Dadda multiplier.
- Accepts 16-bit unsigned products over a valid/ready handshake and sums them into a wider accumulator.
- Closes a frame on a last marker or on reaching the maximum frame length.
- Presents the frame sum, beat count and status flags on an output valid/ready handshake.

---
 rtl/dadda_mac_pkg.sv | 22 ++
 rtl/dadda_mac_accum_add.sv | 36 +++
 rtl/dadda_mac_accum.sv | 137 +++++++++++++
 tb/tb_dadda_mac_accum.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dadda_mac_pkg.sv
// dadda_mac_pkg: shared definitions for the Dadda multiplier accumulator.
//   - state_e     : accumulator FSM states (INIT, ACCUM, DONE)
//   - DEF_*       : default widths for product, accumulator and beat counter
//   - max_count() : maximum frame length 2^cnt_w
package dadda_mac_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_CNT_W  = 8;

    // Maximum number of beats in one frame.
    function automatic logic [31:0] max_count(input int cnt_w);
        max_count = 32'd1 << cnt_w;
    endfunction

endpackage

// File: rtl/dadda_mac_accum_add.sv
// dadda_acc_add: combinational ACC_W-wide adder for the accumulator.
//   acc_in  [ACC_W-1:0]  : current accumulator value
//   prod_in [PROD_W-1:0] : unsigned product, zero-extended to ACC_W
//   sum     [ACC_W-1:0]  : acc_in + prod_in (wrapped, or saturated)
//   carry                : carry out of bit ACC_W-1
// Build option: DADDA_MAC_SAT_EN makes sum saturate to all ones on carry.
module dadda_acc_add
    import dadda_mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod_in,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full_s;

    // One-bit-wider add exposes the carry; saturation keys off that carry.
    always_comb begin
        full_s = {1'b0, acc_in} + (ACC_W+1)'(prod_in);
        carry  = full_s[ACC_W];
`ifdef DADDA_MAC_SAT_EN
        if (full_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = full_s[ACC_W-1:0];
        end
`else
        sum = full_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/dadda_mac_accum.sv
// dadda_mac_accum: streaming frame accumulator behind the 8x8 Dadda multiplier.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   clr                  : synchronous clear; aborts frame, drops pending result
//   prod_valid/ready     : input beat handshake; prod_data, prod_last
//   acc_valid/ready      : result handshake
//   acc_data, acc_count  : frame sum and number of beats
//   acc_ovf, acc_trunc   : sum overflowed during frame / frame closed by length limit
// Build option: DADDA_MAC_SAT_EN selects a saturating accumulator (see dadda_acc_add).
module dadda_mac_accum
    import dadda_mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic [CNT_W:0]    acc_count,
    output logic              acc_ovf,
    output logic              acc_trunc
);

    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(max_count(CNT_W));

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             trunc_q, trunc_d;

    logic [ACC_W-1:0] sum_s;
    logic             carry_s;
    logic [CNT_W:0]   count_inc_s;
    logic             limit_s;

    dadda_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_in  (acc_q),
        .prod_in (prod_data),
        .sum     (sum_s),
        .carry   (carry_s)
    );

    // Count never exceeds MAX_CNT, so the CNT_W+1-bit increment cannot wrap.
    assign count_inc_s = count_q + {{CNT_W{1'b0}}, 1'b1};
    assign limit_s     = (count_inc_s == MAX_CNT);

    assign prod_ready = (state_q == ST_ACCUM) && !clr;
    assign acc_valid  = (state_q == ST_DONE);
    assign acc_data   = acc_q;
    assign acc_count  = count_q;
    assign acc_ovf    = ovf_q;
    assign acc_trunc  = trunc_q;

    // Next-state and accumulator update; clr outranks everything outside INIT.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (clr) begin
                    state_d = ST_ACCUM;
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {(CNT_W+1){1'b0}};
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                end else if (prod_valid) begin
                    acc_d   = sum_s;
                    count_d = count_inc_s;
                    ovf_d   = ovf_q | carry_s;
                    if (prod_last || limit_s) begin
                        state_d = ST_DONE;
                        // A limit beat that also carries last is a normal close.
                        trunc_d = limit_s & ~prod_last;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                // clr and a handshake have the same effect: drop the result.
                if (clr || acc_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {(CNT_W+1){1'b0}};
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_INIT;
                acc_d   = {ACC_W{1'b0}};
                count_d = {(CNT_W+1){1'b0}};
                ovf_d   = 1'b0;
                trunc_d = 1'b0;
            end
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            acc_q   <= {ACC_W{1'b0}};
            count_q <= {(CNT_W+1){1'b0}};
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
        end
    end

endmodule

// File: tb/tb_dadda_mac_accum.sv
// tb_dadda_mac_accum: scoreboard bench for dadda_mac_accum (ACC_W=20, CNT_W=8).
// Build option: DADDA_MAC_SAT_EN selects the saturating expectations.
module tb_dadda_mac_accum;

    localparam int     PROD_W = 16;
    localparam int     ACC_W  = 20;
    localparam int     CNT_W  = 8;
    localparam int     LIMIT  = 256;
    localparam longint MAXV   = (64'd1 << ACC_W) - 64'd1;
`ifdef DADDA_MAC_SAT_EN
    localparam logic [31:0] T3_DATA = 32'd1048575;
`else
    localparam logic [31:0] T3_DATA = 32'd56849;
`endif

    typedef struct {
        logic [31:0] data;
        logic [31:0] count;
        logic [31:0] ovf;
        logic [31:0] trunc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              prod_last;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic [CNT_W:0]    acc_count;
    logic              acc_ovf;
    logic              acc_trunc;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t   sb_q[$];
    exp_t   mon_e;
    exp_t   exp_new;
    longint m_acc = 0;
    longint m_sum;
    int     m_cnt = 0;
    bit     m_ovf = 0;
    int     acc_beats = 0;
    bit     close_seen = 0;
    logic [31:0] last_data, last_count, last_ovf, last_trunc;

    dadda_mac_accum #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .prod_last  (prod_last),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .acc_count  (acc_count),
        .acc_ovf    (acc_ovf),
        .acc_trunc  (acc_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor and reference model, sampled one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            sb_q.delete();
            m_acc = 0; m_cnt = 0; m_ovf = 0; close_seen = 0;
        end else begin
            if (close_seen) begin
                chk_eq("valid_latency", 32'(acc_valid), 32'd1);
                close_seen = 0;
            end
            if (clr) begin
                if (acc_valid && sb_q.size() > 0) mon_e = sb_q.pop_front();
                m_acc = 0; m_cnt = 0; m_ovf = 0;
            end else begin
                if (acc_valid && acc_ready) begin
                    chk_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        mon_e = sb_q.pop_front();
                        chk_eq("sb_data",  32'(acc_data),  mon_e.data);
                        chk_eq("sb_count", 32'(acc_count), mon_e.count);
                        chk_eq("sb_ovf",   32'(acc_ovf),   mon_e.ovf);
                        chk_eq("sb_trunc", 32'(acc_trunc), mon_e.trunc);
                    end
                    last_data  = 32'(acc_data);
                    last_count = 32'(acc_count);
                    last_ovf   = 32'(acc_ovf);
                    last_trunc = 32'(acc_trunc);
                end
                if (prod_valid && prod_ready) begin
                    acc_beats++;
                    m_sum = m_acc + longint'(prod_data);
                    m_cnt++;
                    if (m_sum > MAXV) begin
                        m_ovf = 1;
`ifdef DADDA_MAC_SAT_EN
                        m_acc = MAXV;
`else
                        m_acc = m_sum - (MAXV + 64'd1);
`endif
                    end else begin
                        m_acc = m_sum;
                    end
                    if (prod_last || m_cnt == LIMIT) begin
                        exp_new.data  = 32'(m_acc);
                        exp_new.count = 32'(m_cnt);
                        exp_new.ovf   = 32'(m_ovf);
                        exp_new.trunc = 32'(!prod_last);
                        sb_q.push_back(exp_new);
                        m_acc = 0; m_cnt = 0; m_ovf = 0;
                        close_seen = 1;
                    end
                end
            end
        end
    end

    // Present one beat from a falling edge and hold it until accepted.
    task automatic send_beat(input logic [15:0] d, input logic l);
        int n0;
        bit done;
        n0 = acc_beats;
        done = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = l;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (acc_beats != n0) done = 1;
        end
        chk_eq("beat_accept", 32'(done), 32'd1);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        chk_eq("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst_n = 1'b0; clr = 1'b0; prod_valid = 1'b0; prod_data = '0;
        prod_last = 1'b0; acc_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("rst_valid", 32'(acc_valid), 32'd0);
        chk_eq("rst_ready", 32'(prod_ready), 32'd0);
        chk_eq("rst_data",  32'(acc_data), 32'd0);
        chk_eq("rst_count", 32'(acc_count), 32'd0);
        chk_eq("rst_flags", 32'({acc_ovf, acc_trunc}), 32'd0);
        rst_n = 1'b1;
        #4;
        chk_eq("init_ready", 32'(prod_ready), 32'd0);
        @(negedge clk);
        chk_eq("accum_ready", 32'(prod_ready), 32'd1);

        // 1: four full-scale products
        for (int i = 0; i < 4; i++) send_beat(16'd65025, i == 3);
        chk_eq("t1_ready_done", 32'(prod_ready), 32'd0);
        @(negedge clk);
        chk_eq("t1_ready_after", 32'(prod_ready), 32'd1);
        drain();
        chk_eq("t1_data", last_data, 32'd260100);
        chk_eq("t1_count", last_count, 32'd4);
        chk_eq("t1_flags", {last_ovf[0], last_trunc[0]}, 32'd0);

        // 2: result held under back-pressure, next beat blocked
        acc_ready = 1'b0;
        send_beat(16'd9, 1'b1);
        nb = acc_beats;
        prod_valid = 1'b1; prod_data = 16'd5; prod_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_eq("t2_valid", 32'(acc_valid), 32'd1);
            chk_eq("t2_data", 32'(acc_data), 32'd9);
            chk_eq("t2_count", 32'(acc_count), 32'd1);
            chk_eq("t2_ready", 32'(prod_ready), 32'd0);
            @(negedge clk);
        end
        chk_eq("t2_no_accept", 32'(acc_beats - nb), 32'd0);
        acc_ready = 1'b1;
        send_beat(16'd5, 1'b1);
        drain();
        chk_eq("t2_next_data", last_data, 32'd5);

        // 3: overflow across 17 full-scale beats
        for (int i = 0; i < 17; i++) send_beat(16'd65025, i == 16);
        drain();
        chk_eq("t3_data", last_data, T3_DATA);
        chk_eq("t3_count", last_count, 32'd17);
        chk_eq("t3_ovf", last_ovf, 32'd1);

        // 4: length limit without and with last
        for (int i = 0; i < LIMIT; i++) send_beat(16'd1, 1'b0);
        drain();
        chk_eq("t4a_data", last_data, 32'd256);
        chk_eq("t4a_count", last_count, 32'd256);
        chk_eq("t4a_trunc", last_trunc, 32'd1);
        for (int i = 0; i < LIMIT; i++) send_beat(16'd1, i == LIMIT - 1);
        drain();
        chk_eq("t4b_count", last_count, 32'd256);
        chk_eq("t4b_trunc", last_trunc, 32'd0);

        // 5: clear mid-frame
        for (int i = 0; i < 3; i++) send_beat(16'd100, 1'b0);
        nb = acc_beats;
        clr = 1'b1; prod_valid = 1'b1; prod_data = 16'd50; prod_last = 1'b1;
        #1;
        chk_eq("t5_clr_ready", 32'(prod_ready), 32'd0);
        chk_eq("t5_clr_valid", 32'(acc_valid), 32'd0);
        @(negedge clk);
        clr = 1'b0; prod_valid = 1'b0; prod_last = 1'b0;
        chk_eq("t5_no_accept", 32'(acc_beats - nb), 32'd0);
        send_beat(16'd7, 1'b1);
        drain();
        chk_eq("t5_data", last_data, 32'd7);
        chk_eq("t5_count", last_count, 32'd1);

        // 6: asynchronous reset while holding a result
        acc_ready = 1'b0;
        send_beat(16'd3, 1'b1);
        chk_eq("t6_valid_before", 32'(acc_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("t6_valid_rst", 32'(acc_valid), 32'd0);
        chk_eq("t6_ready_rst", 32'(prod_ready), 32'd0);
        chk_eq("t6_data_rst", 32'(acc_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acc_ready = 1'b1;
        #4;
        chk_eq("t6_init_ready", 32'(prod_ready), 32'd0);
        @(negedge clk);
        chk_eq("t6_accum_ready", 32'(prod_ready), 32'd1);
        chk_eq("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
